// File: rtl/wlc_pkg.sv
// -----------------------------------------------------------------------------
// wlc_pkg
// Shared types and sizing for the weight_load_ctrl slice.
//   state_t    : controller states IDLE / LOAD / FLUSH / READY
//   WLC_NUM_W  : weights per 5x5 kernel
//   WLC_ADDR_W : weight-file address width
//   WLC_DATA_W : signed weight width
//   WLC_CSUM_W : checksum width (16-bit wraparound sum)
// -----------------------------------------------------------------------------
package wlc_pkg;

   localparam int WLC_NUM_W  = 25;
   localparam int WLC_ADDR_W = 5;
   localparam int WLC_DATA_W = 8;
   localparam int WLC_CSUM_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      READY = 2'd3
   } state_t;

endpackage : wlc_pkg

// File: rtl/weight_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl_if
// Valid/ready stream carrying signed weights into weight_load_ctrl.
//   w       : signed weight data (DATA_W bits)
//   w_valid : source has a weight on w
//   w_ready : controller accepts a weight this cycle
// Modports: master = weight source, slave = weight_load_ctrl.
// -----------------------------------------------------------------------------
interface weight_load_ctrl_if #(
   parameter int DATA_W = wlc_pkg::WLC_DATA_W
);

   logic [DATA_W-1:0] w;
   logic              w_valid;
   logic              w_ready;

   modport master (output w, output w_valid, input  w_ready);
   modport slave  (input  w, input  w_valid, output w_ready);

endinterface : weight_load_ctrl_if

// File: rtl/wlc_csum_acc.sv
// -----------------------------------------------------------------------------
// wlc_csum_acc
// 16-bit signed running sum of accepted weights (wraparound).
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_clr          : zero the sum (wins over i_en)
//   i_en           : add sign-extended i_w this cycle
//   i_w            : signed weight
//   o_sum          : current registered sum
// Only instantiated when WEIGHT_LOAD_CSUM_EN is defined.
// -----------------------------------------------------------------------------
module wlc_csum_acc
   import wlc_pkg::*;
#(
   parameter int DATA_W = WLC_DATA_W
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_clr,
   input  logic                  i_en,
   input  logic [DATA_W-1:0]     i_w,
   output logic [WLC_CSUM_W-1:0] o_sum
);

   logic [WLC_CSUM_W-1:0] sum_d;
   logic [WLC_CSUM_W-1:0] sum_q;

   always_comb begin
      sum_d = sum_q;
      if (i_clr) begin
         sum_d = '0;
      end else if (i_en) begin
         sum_d = sum_q + {{(WLC_CSUM_W - DATA_W){i_w[DATA_W-1]}}, i_w};
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) sum_q <= '0;
      else          sum_q <= sum_d;
   end

   assign o_sum = sum_q;

endmodule : wlc_csum_acc

// File: rtl/weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl
// Sequencer for the 5x5 conv weight register file. Accepts a valid/ready
// stream of signed weights and writes them to addresses 0..NUM_W-1, then
// flags a stable kernel to the MAC array.
//
// Ports
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_start         : pulse, begin a kernel load (IDLE or READY)
//   i_release       : pulse, drop the kernel / abort a load (wins over i_start)
//   w_if (slave)    : weight stream w / w_valid / w_ready
//   i_csum          : expected signed weight sum, latched on i_start
//   o_st_w          : weight-file write data
//   o_st_addr       : weight-file address
//   o_st_wr_en      : weight-file write enable
//   o_st_valid      : weight-file valid; low makes the file clear itself
//   o_kernel_ready  : all weights resident and stable
//   o_busy          : controller not IDLE
//   o_err_timeout   : sticky, last load aborted by stream timeout
//   o_err_csum      : sticky, last load failed checksum
//
// Build option: define WEIGHT_LOAD_CSUM_EN to accumulate and check the weight
// checksum in FLUSH. Without it i_csum is ignored and o_err_csum stays 0.
// All outputs are registered and derived from the next state.
// -----------------------------------------------------------------------------
module weight_load_ctrl
   import wlc_pkg::*;
#(
   parameter int NUM_W        = WLC_NUM_W,
   parameter int ADDR_W       = WLC_ADDR_W,
   parameter int DATA_W       = WLC_DATA_W,
   parameter int LOAD_TIMEOUT = 1024
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_release,
   weight_load_ctrl_if.slave     w_if,
   input  logic [WLC_CSUM_W-1:0] i_csum,
   output logic [DATA_W-1:0]     o_st_w,
   output logic [ADDR_W-1:0]     o_st_addr,
   output logic                  o_st_wr_en,
   output logic                  o_st_valid,
   output logic                  o_kernel_ready,
   output logic                  o_busy,
   output logic                  o_err_timeout,
   output logic                  o_err_csum
);

   localparam int                IDLE_W      = $clog2(LOAD_TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_W - 1);
   localparam logic [IDLE_W-1:0] TIMEOUT_CNT = IDLE_W'(LOAD_TIMEOUT);

   state_t              state_d, state_q;
   logic [ADDR_W-1:0]   cnt_d, cnt_q;
   logic [IDLE_W-1:0]   idle_cnt_d, idle_cnt_q;
   logic [DATA_W-1:0]   st_w_d, st_w_q;
   logic [ADDR_W-1:0]   st_addr_d, st_addr_q;
   logic                st_wr_en_d, st_wr_en_q;
   logic                err_timeout_d, err_timeout_q;
   logic                err_csum_d, err_csum_q;
   logic                st_valid_q, w_ready_q, kernel_ready_q, busy_q;
   logic                hs;

   // w_ready_q is only ever high in LOAD, so this is the LOAD handshake.
   assign hs = w_if.w_valid & w_ready_q;

`ifdef WEIGHT_LOAD_CSUM_EN
   logic [WLC_CSUM_W-1:0] csum_d, csum_q;
   logic [WLC_CSUM_W-1:0] acc_sum;
   logic                  acc_clr;

   wlc_csum_acc #(.DATA_W(DATA_W)) u_csum_acc (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (acc_clr),
      .i_en    (hs),
      .i_w     (w_if.w),
      .o_sum   (acc_sum)
   );
`else
   logic csum_unused;
   assign csum_unused = ^i_csum;
`endif

   // NOTE: every signal driven here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idle_cnt_d    = idle_cnt_q;
      st_w_d        = st_w_q;
      st_addr_d     = st_addr_q;
      st_wr_en_d    = 1'b0;
      err_timeout_d = err_timeout_q;
      err_csum_d    = err_csum_q;
`ifdef WEIGHT_LOAD_CSUM_EN
      csum_d        = csum_q;
      acc_clr       = 1'b0;
`endif

      if (i_release) begin
         // Release beats a simultaneous start; dropping o_st_valid clears the file.
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, READY: begin
               if (i_start) begin
                  state_d       = LOAD;
                  cnt_d         = '0;
                  idle_cnt_d    = '0;
                  err_timeout_d = 1'b0;
                  err_csum_d    = 1'b0;
`ifdef WEIGHT_LOAD_CSUM_EN
                  csum_d        = i_csum;
                  acc_clr       = 1'b1;
`endif
               end
            end
            LOAD: begin
               if (hs) begin
                  st_w_d     = w_if.w;
                  st_addr_d  = cnt_q;
                  st_wr_en_d = 1'b1;
                  cnt_d      = cnt_q + 1'b1;
                  idle_cnt_d = '0;
                  if (cnt_q == LAST_ADDR) state_d = FLUSH;
               end else begin
                  idle_cnt_d = idle_cnt_q + 1'b1;
                  if (idle_cnt_d == TIMEOUT_CNT) begin
                     state_d       = IDLE;
                     err_timeout_d = 1'b1;
                  end
               end
            end
            FLUSH: begin
               // The final write is on the file's inputs during this cycle.
               state_d = READY;
`ifdef WEIGHT_LOAD_CSUM_EN
               if (acc_sum != csum_q) begin
                  state_d    = IDLE;
                  err_csum_d = 1'b1;
               end
`endif
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         idle_cnt_q     <= '0;
         st_w_q         <= '0;
         st_addr_q      <= '0;
         st_wr_en_q     <= 1'b0;
         st_valid_q     <= 1'b0;
         w_ready_q      <= 1'b0;
         kernel_ready_q <= 1'b0;
         busy_q         <= 1'b0;
         err_timeout_q  <= 1'b0;
         err_csum_q     <= 1'b0;
`ifdef WEIGHT_LOAD_CSUM_EN
         csum_q         <= '0;
`endif
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         idle_cnt_q     <= idle_cnt_d;
         st_w_q         <= st_w_d;
         st_addr_q      <= st_addr_d;
         st_wr_en_q     <= st_wr_en_d;
         // Registered status follows the state being entered on this edge.
         st_valid_q     <= (state_d != IDLE);
         w_ready_q      <= (state_d == LOAD);
         kernel_ready_q <= (state_d == READY);
         busy_q         <= (state_d != IDLE);
         err_timeout_q  <= err_timeout_d;
         err_csum_q     <= err_csum_d;
`ifdef WEIGHT_LOAD_CSUM_EN
         csum_q         <= csum_d;
`endif
      end
   end

   assign w_if.w_ready   = w_ready_q;
   assign o_st_w         = st_w_q;
   assign o_st_addr      = st_addr_q;
   assign o_st_wr_en     = st_wr_en_q;
   assign o_st_valid     = st_valid_q;
   assign o_kernel_ready = kernel_ready_q;
   assign o_busy         = busy_q;
   assign o_err_timeout  = err_timeout_q;
   assign o_err_csum     = err_csum_q;

endmodule : weight_load_ctrl

// File: tb/tb_weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_load_ctrl
// Self-checking bench for weight_load_ctrl (LOAD_TIMEOUT = 16). A behavioural
// weight file captures the controller's writes; expectations come from the
// weight list, a handshake count and the load rules.
// -----------------------------------------------------------------------------
module tb_weight_load_ctrl;

   localparam int NW = 25;
   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        rel;
   logic [15:0] csum;
   logic [7:0]  st_w;
   logic [4:0]  st_addr;
   logic        st_wr_en, st_valid, kernel_ready, busy, err_timeout, err_csum;

   weight_load_ctrl_if #(.DATA_W(8)) w_if ();

   weight_load_ctrl #(.LOAD_TIMEOUT(TO)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_start        (start),
      .i_release      (rel),
      .w_if           (w_if),
      .i_csum         (csum),
      .o_st_w         (st_w),
      .o_st_addr      (st_addr),
      .o_st_wr_en     (st_wr_en),
      .o_st_valid     (st_valid),
      .o_kernel_ready (kernel_ready),
      .o_busy         (busy),
      .o_err_timeout  (err_timeout),
      .o_err_csum     (err_csum)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic signed [7:0] wts [NW];     // weights for the current load
   logic signed [7:0] file_m [NW];  // behavioural weight register file
   int                n_acc;        // weights accepted in the current load

   // Weight file: clears while valid is low, otherwise takes writes.
   always @(posedge clk) begin
      if (!st_valid) begin
         for (int i = 0; i < NW; i++) file_m[i] <= '0;
      end else if (st_wr_en && st_addr < 5'(NW)) begin
         file_m[st_addr] <= st_w;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] weight_sum();
      int s = 0;
      for (int i = 0; i < NW; i++) s += int'(wts[i]);
      return s[15:0];
   endfunction

   // Present weights until n_acc reaches n; each handshake must show up as a
   // write to address n_acc one cycle later. mode 0: always valid,
   // 1: valid toggles (plus an ignored i_start), 2: random gaps.
   task automatic feed(input int n, input int mode, input string tag);
      int cyc = 0;
      int gap = 0;
      bit hs;
      while (n_acc < n && cyc < 400) begin
         case (mode)
            0:       w_if.w_valid = 1'b1;
            1:       w_if.w_valid = (cyc % 2 == 0);
            default: w_if.w_valid = (gap >= 6) ? 1'b1 : ($urandom_range(0, 2) != 0);
         endcase
         gap   = w_if.w_valid ? 0 : gap + 1;
         start = (mode == 1 && n_acc == 7 && !w_if.w_valid);
         w_if.w = wts[n_acc];
         n_checks++;
         if (w_if.w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s w_ready in LOAD: got %b want 1 (acc=%0d)", tag, w_if.w_ready, n_acc);
         end
         hs = w_if.w_valid;
         step();
         start = 1'b0;
         n_checks++;
         if (st_wr_en !== hs) begin
            n_fail++;
            $display("FAIL %s wr_en: got %b want %b (acc=%0d)", tag, st_wr_en, hs, n_acc);
         end
         if (hs) begin
            n_checks++;
            if (st_addr !== 5'(n_acc) || st_w !== wts[n_acc]) begin
               n_fail++;
               $display("FAIL %s write: got addr %0d data %0d want addr %0d data %0d",
                        tag, st_addr, $signed(st_w), n_acc, wts[n_acc]);
            end
            n_acc++;
         end
         cyc++;
      end
      w_if.w_valid = 1'b0;
      if (n_acc < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s feed timeout: accepted %0d want %0d", tag, n_acc, n);
      end
   endtask

   task automatic do_start(input logic [15:0] cs, input string tag);
      start = 1'b1;
      csum  = cs;
      step();
      start = 1'b0;
      n_acc = 0;
      n_checks++;
      if (busy !== 1'b1 || st_valid !== 1'b1 || kernel_ready !== 1'b0 ||
          err_timeout !== 1'b0 || err_csum !== 1'b0) begin
         n_fail++;
         $display("FAIL %s enter LOAD: busy %b valid %b kready %b errs %b%b want 1 1 0 00",
                  tag, busy, st_valid, kernel_ready, err_timeout, err_csum);
      end
   endtask

   // Full load; exp_ok says whether the kernel should end up ready.
   task automatic run_load(input int mode, input logic [15:0] cs, input bit exp_ok, input string tag);
      do_start(cs, tag);
      feed(NW, mode, tag);
      n_checks++;
      if (w_if.w_ready !== 1'b0 || busy !== 1'b1 || kernel_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL %s flush cycle: ready %b busy %b kready %b want 0 1 0",
                  tag, w_if.w_ready, busy, kernel_ready);
      end
      step();
      n_checks++;
      if (kernel_ready !== exp_ok || busy !== exp_ok || st_valid !== exp_ok || st_wr_en !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after flush: kready %b busy %b valid %b wr_en %b want %b %b %b 0",
                  tag, kernel_ready, busy, st_valid, st_wr_en, exp_ok, exp_ok, exp_ok);
      end
      if (exp_ok) begin
         step();
         step();
         for (int i = 0; i < NW; i++) begin
            n_checks++;
            if (file_m[i] !== wts[i]) begin
               n_fail++;
               $display("FAIL %s file[%0d]: got %0d want %0d", tag, i, file_m[i], wts[i]);
            end
         end
         n_checks++;
         if (kernel_ready !== 1'b1 || st_addr !== 5'(NW - 1) || st_w !== wts[NW-1] || st_wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready hold: kready %b addr %0d data %0d wr_en %b want 1 %0d %0d 0",
                     tag, kernel_ready, st_addr, $signed(st_w), st_wr_en, NW - 1, wts[NW-1]);
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      rel   = 1'b0;
      csum  = '0;
      w_if.w = '0;
      w_if.w_valid = 1'b0;
      repeat (3) step();
      n_checks++;
      if ({st_w, st_addr, st_wr_en, st_valid, kernel_ready, busy, err_timeout, err_csum, w_if.w_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset outputs: w %h addr %h wr %b v %b kr %b busy %b et %b ec %b rdy %b want all 0",
                  st_w, st_addr, st_wr_en, st_valid, kernel_ready, busy, err_timeout, err_csum, w_if.w_ready);
      end
      rst_n = 1'b1;
      start = 1'b0;
      step();
      n_checks++;
      if (busy !== 1'b0 || st_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset idle: busy %b valid %b want 0 0", busy, st_valid);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < NW; i++) wts[i] = 8'(i - 12);
      run_load(0, weight_sum(), 1'b1, "seq");
   endtask

   task automatic test_toggle();
      for (int i = 0; i < NW; i++) wts[i] = 8'(i - 12);
      run_load(1, weight_sum(), 1'b1, "toggle");
   endtask

   task automatic test_random();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NW; i++) wts[i] = 8'($urandom);
         run_load(2, weight_sum(), 1'b1, "random");
      end
   endtask

   task automatic test_release();
      for (int i = 0; i < NW; i++) wts[i] = 8'($urandom);
      do_start(weight_sum(), "release");
      feed(10, 0, "release");
      rel = 1'b1;
      step();
      rel = 1'b0;
      n_checks++;
      if (st_valid !== 1'b0 || busy !== 1'b0 || kernel_ready !== 1'b0 || w_if.w_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL release: valid %b busy %b kready %b ready %b want 0 0 0 0",
                  st_valid, busy, kernel_ready, w_if.w_ready);
      end
      step();
      n_checks++;
      if (file_m[0] !== 8'sd0 || file_m[9] !== 8'sd0) begin
         n_fail++;
         $display("FAIL release clear: file[0] %0d file[9] %0d want 0 0", file_m[0], file_m[9]);
      end
      run_load(0, weight_sum(), 1'b1, "reload");
   endtask

   task automatic test_release_wins();
      start = 1'b1;
      rel   = 1'b1;
      step();
      start = 1'b0;
      rel   = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || st_valid !== 1'b0 || kernel_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL start+release: busy %b valid %b kready %b want 0 0 0", busy, st_valid, kernel_ready);
      end
   endtask

   task automatic test_timeout();
      for (int i = 0; i < NW; i++) wts[i] = 8'($urandom);
      do_start(16'h0, "timeout");
      feed(5, 0, "timeout");
      for (int s = 1; s <= TO; s++) begin
         n_checks++;
         if (busy !== 1'b1 || err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout early at stall %0d: busy %b err %b want 1 0", s, busy, err_timeout);
         end
         step();
      end
      n_checks++;
      if (busy !== 1'b0 || err_timeout !== 1'b1 || st_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout abort: busy %b err %b valid %b want 0 1 0", busy, err_timeout, st_valid);
      end
      step();
      n_checks++;
      if (err_timeout !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout sticky: got %b want 1", err_timeout);
      end
      // do_start also requires the error to be cleared on entering LOAD.
      run_load(0, weight_sum(), 1'b1, "after_timeout");
   endtask

   task automatic test_csum();
      bit csum_on;
`ifdef WEIGHT_LOAD_CSUM_EN
      csum_on = 1'b1;
`else
      csum_on = 1'b0;
`endif
      for (int i = 0; i < NW; i++) wts[i] = 8'sd1;
      run_load(0, 16'd25, 1'b1, "csum_good");
      run_load(0, 16'd24, !csum_on, "csum_bad");
      n_checks++;
      if (err_csum !== csum_on) begin
         n_fail++;
         $display("FAIL csum err flag: got %b want %b", err_csum, csum_on);
      end
      rel = 1'b1;
      step();
      rel = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sequential();
      test_toggle();
      test_random();
      test_release();
      test_release_wins();
      test_timeout();
      test_csum();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_weight_load_ctrl
